// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ clients.
// The winner's addr/data/rw are latched and held while gnt is set. The master
// is enabled until it reports busy. When the transfer ends, the owner receives
// a one-cycle ack or err pulse.
module i2c_req_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]   req_rw,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic [7:0]           rdata,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data_in,
  output logic                 m_rw,
  output logic                 m_enable,
  input  logic [7:0]           m_data_out,
  input  logic                 m_busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(START_TIMEOUT + 1);
  // The final LAUNCH cycle before giving up; LAUNCH lasts START_TIMEOUT cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLaunch,
    StWaitDone,
    StComplete,
    StFail
  } state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_rr;
  logic [CntW-1:0]     r_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_err;
  logic [7:0]          r_rdata;
  logic [6:0]          r_m_addr;
  logic [7:0]          r_m_data_in;
  logic                r_m_rw;
  logic                r_m_enable;

  logic                w_found;
  logic [IdxW-1:0]     w_idx;
  logic [IdxW-1:0]     w_win;
  logic [IdxW-1:0]     w_rr_next;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [6:0]          w_win_addr;
  logic [7:0]          w_win_wdata;
  logic                w_win_rw;

  // Winner search: first asserted request scanning upward from the rr pointer.
  always_comb begin
    w_found     = 1'b0;
    w_idx       = '0;
    w_win       = '0;
    w_win_oh    = '0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_win_rw    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = IdxW'((32'(r_rr) + i) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (w_win == IdxW'(j)) begin
        w_win_oh[j] = 1'b1;
        w_win_addr  = req_addr[7*j +: 7];
        w_win_wdata = req_wdata[8*j +: 8];
        w_win_rw    = req_rw[j];
      end
    end
    w_rr_next = (w_win == IdxW'(NUM_REQ - 1)) ? '0 : w_win + IdxW'(1);
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state     <= StIdle;
      r_rr        <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
      r_m_addr    <= '0;
      r_m_data_in <= '0;
      r_m_rw      <= 1'b0;
      r_m_enable  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // A busy master means it is not idle yet; hold off arbitration.
          if (!m_busy && |req) r_state <= StArb;
        end
        StArb: begin
          if (w_found) begin
            r_gnt       <= w_win_oh;
            r_m_addr    <= w_win_addr;
            r_m_data_in <= w_win_wdata;
            r_m_rw      <= w_win_rw;
            r_rr        <= w_rr_next;
            r_m_enable  <= 1'b1;
            r_cnt       <= '0;
            r_state     <= StLaunch;
          end else begin
            // Request withdrawn before arbitration; nothing to do.
            r_state <= StIdle;
          end
        end
        StLaunch: begin
          if (m_busy) begin
            r_m_enable <= 1'b0;
            r_state    <= StWaitDone;
          end else if (r_cnt == CntLast) begin
            r_m_enable <= 1'b0;
            r_err      <= r_gnt;
            r_state    <= StFail;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitDone: begin
          if (!m_busy) begin
            r_ack <= r_gnt;
            if (r_m_rw) r_rdata <= m_data_out;
            r_state <= StComplete;
          end
        end
        StComplete: begin
          r_ack   <= '0;
          r_gnt   <= '0;
          r_state <= StIdle;
        end
        StFail: begin
          r_err   <= '0;
          r_gnt   <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign m_addr    = r_m_addr;
  assign m_data_in = r_m_data_in;
  assign m_rw      = r_m_rw;
  assign m_enable  = r_m_enable;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a scoreboard of expected responses
// and a simple busy-stub model of the i2c_master.
module tb_i2c_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 255;

  logic           clk = 1'b0;
  logic           areset;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   req_rw;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic [7:0]     rdata;
  logic [6:0]     m_addr;
  logic [7:0]     m_data_in;
  logic           m_rw;
  logic           m_enable;
  logic [7:0]     m_data_out;
  logic           m_busy;

  i2c_req_arbiter #(
    .NUM_REQ       (N),
    .START_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .req        (req),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rw     (req_rw),
    .gnt        (gnt),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_rw       (m_rw),
    .m_enable   (m_enable),
    .m_data_out (m_data_out),
    .m_busy     (m_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         client;
    bit         is_err;
    bit         is_rd;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [N-1:0] hold = '0;
  bit         stub_en = 1'b0;
  int         busy_len = 3;
  int         stub_cnt = 0;
  logic [7:0] slave_rdata = 8'h00;

  // Master stub: raises busy once enabled, drops it busy_len cycles later.
  always @(posedge clk) begin
    #1;
    if (!areset) begin
      m_busy   = 1'b0;
      stub_cnt = 0;
    end else if (stub_en) begin
      if (m_busy) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          m_busy     = 1'b0;
          m_data_out = slave_rdata;
        end
      end else if (m_enable) begin
        m_busy   = 1'b1;
        stub_cnt = busy_len;
      end
    end
  end

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v = '0;
    v[2'(c)] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b0;
    req    = '0;
    hold   = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    areset = 1'b1;
  endtask

  // Drive one client request and push its expected response.
  task automatic request(input int c, input logic [6:0] a, input logic [7:0] d,
                         input logic rw, input bit is_err);
    exp_t e;
    req_addr[7*c +: 7]  = a;
    req_wdata[8*c +: 8] = d;
    req_rw[2'(c)]       = rw;
    req[2'(c)]          = 1'b1;
    e.client = c;
    e.is_err = is_err;
    e.is_rd  = rw;
    e.addr   = a;
    e.wdata  = d;
    e.rdata  = slave_rdata;
    sb.push_back(e);
  endtask

  // Wait for the next ack/err, pop the scoreboard and compare.
  task automatic collect(input int budget, output int en_first);
    exp_t         e;
    bit           got = 1'b0;
    bit           seen = 1'b0;
    bit           gbad = 1'b0;
    int           en_cnt = 0;
    logic [6:0]   a = '0;
    logic [7:0]   d = '0;
    logic         w = 1'b0;
    logic [N-1:0] peek_oh = '0;
    en_first = -1;
    if (sb.size() != 0) peek_oh = oh(sb[0].client);
    for (int cyc = 0; cyc < budget && !got; cyc++) begin
      @(negedge clk);
      if (m_enable) begin
        if (!seen) begin
          seen     = 1'b1;
          en_first = cyc;
          a        = m_addr;
          d        = m_data_in;
          w        = m_rw;
        end
        en_cnt++;
      end
      if (seen && gnt !== peek_oh) gbad = 1'b1;
      if (|ack || |err) got = 1'b1;
    end
    check("resp_seen", 64'(got), 64'd1);
    if (!got) return;
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (e.is_err) begin
      check("err_bit", 64'(err), 64'(oh(e.client)));
      check("ack_none", 64'(ack), 64'd0);
      check("launch_cycles", 64'(en_cnt), 64'(TO));
    end else begin
      check("ack_bit", 64'(ack), 64'(oh(e.client)));
      check("err_none", 64'(err), 64'd0);
      check("m_addr", 64'(a), 64'(e.addr));
      check("m_data_in", 64'(d), 64'(e.wdata));
      check("m_rw", 64'(w), 64'(e.is_rd));
      check("enable_cycles", 64'(en_cnt), 64'd1);
      if (e.is_rd) check("rdata", 64'(rdata), 64'(e.rdata));
    end
    check("gnt_at_resp", 64'(gnt), 64'(oh(e.client)));
    check("gnt_hold", 64'(gbad), 64'd0);
    if (!hold[2'(e.client)]) req[2'(e.client)] = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  found;
    logic [N-1:0] any_resp;
    areset     = 1'b0;
    req        = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_rw     = '0;
    m_data_out = '0;
    m_busy     = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_outputs", 64'({gnt, ack, err, m_enable, m_addr, m_data_in, m_rw, rdata}), 64'd0);
    @(negedge clk);
    areset  = 1'b1;
    stub_en = 1'b1;

    // 1: single write, enable two edges after req.
    request(0, 7'h57, 8'hAA, 1'b0, 1'b0);
    collect(50, lat);
    check("req_to_enable", 64'(lat), 64'd1);

    // 2: single read from client 2.
    slave_rdata = 8'hCD;
    request(2, 7'h57, 8'h00, 1'b1, 1'b0);
    collect(50, lat);

    // rdata holds across a later write.
    request(0, 7'h10, 8'h01, 1'b0, 1'b0);
    collect(50, lat);
    check("rdata_held", 64'(rdata), 64'hCD);

    // Busy master blocks arbitration.
    stub_en = 1'b0;
    m_busy  = 1'b1;
    request(3, 7'h33, 8'h44, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("busy_blocks_grant", 64'({gnt, m_enable}), 64'd0);
    m_busy  = 1'b0;
    stub_en = 1'b1;
    collect(50, lat);

    // 3: all four at once from reset, twice.
    do_reset();
    slave_rdata = 8'h3C;
    for (int r = 0; r < 2; r++) begin
      request(0, 7'h01, 8'h11, 1'b0, 1'b0);
      request(1, 7'h02, 8'h22, 1'b0, 1'b0);
      request(2, 7'h03, 8'h33, 1'b1, 1'b0);
      request(3, 7'h04, 8'h44, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) collect(50, lat);
    end

    // 4: req[1] and req[3] held -> 1,3,1,3.
    hold = 4'b1010;
    request(1, 7'h21, 8'hA1, 1'b0, 1'b0);
    request(3, 7'h23, 8'hA3, 1'b0, 1'b0);
    request(1, 7'h21, 8'hA1, 1'b0, 1'b0);
    request(3, 7'h23, 8'hA3, 1'b0, 1'b0);
    collect(50, lat);
    collect(50, lat);
    hold = '0;
    collect(50, lat);
    collect(50, lat);

    // 5: master never busy -> timeout error, then a normal transfer.
    stub_en = 1'b0;
    request(2, 7'h11, 8'h22, 1'b0, 1'b1);
    collect(TO + 20, lat);
    stub_en = 1'b1;
    request(1, 7'h12, 8'h34, 1'b0, 1'b0);
    collect(50, lat);

    // 6: reset during WAIT_DONE.
    busy_len = 6;
    req_addr[7*1 +: 7]  = 7'h2A;
    req_wdata[8*1 +: 8] = 8'h5A;
    req_rw[1]           = 1'b0;
    req[1]              = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (m_busy && !m_enable && gnt === oh(1)) found = 1'b1;
    end
    check("reach_wait_done", 64'(found), 64'd1);
    #2;
    areset = 1'b0;
    #1;
    check("rst_async_outputs",
          64'({gnt, ack, err, m_enable, m_addr, m_data_in, m_rw, rdata}), 64'd0);
    req = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    areset   = 1'b1;
    busy_len = 3;
    any_resp = '0;
    repeat (5) begin
      @(negedge clk);
      any_resp = any_resp | ack | err;
    end
    check("no_resp_after_reset", 64'(any_resp), 64'd0);
    slave_rdata = 8'h9E;
    request(0, 7'h05, 8'h50, 1'b0, 1'b0);
    request(2, 7'h06, 8'h60, 1'b1, 1'b0);
    collect(50, lat);
    collect(50, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
